// File: rtl/s2p_comma_aligner.sv
// Serial-to-parallel receiver that aligns 10-bit words on the 8b/10b K28.5 comma
// and tracks link lock with a HUNT/CHECK/LOCKED state machine.
module s2p_comma_aligner #(
  parameter int                 WIDTH      = 10,
  parameter logic [WIDTH-1:0]   COMMA_N    = 10'h17C,
  parameter logic [WIDTH-1:0]   COMMA_P    = 10'h283,
  parameter int                 LOCK_COUNT = 3,
  parameter int                 LOSS_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             comma_det,
  output logic             locked
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TH  = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TH  = 4'(LOSS_COUNT);
  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [3:0]       bit_cnt;
  logic [3:0]       good_cnt;
  logic [3:0]       bad_cnt;

  logic [WIDTH-1:0] win;
  logic             is_comma;
  logic             boundary;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Window of the ten most recent bits (oldest at bit0) and its classification.
  always_comb begin
    win      = {serial_in, shift_reg[WIDTH-1:1]};
    is_comma = (win == COMMA_N) || (win == COMMA_P);
    boundary = (bit_cnt == LAST_BIT);
    good_inc = sat_inc(good_cnt);
    bad_inc  = sat_inc(bad_cnt);
  end

  // Shift register, word phase counter, lock FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      shift_reg    <= '0;
      bit_cnt      <= 4'd0;
      good_cnt     <= 4'd0;
      bad_cnt      <= 4'd0;
      parallel_out <= '0;
      word_valid   <= 1'b0;
      comma_det    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      shift_reg  <= win;
      word_valid <= 1'b0;
      comma_det  <= 1'b0;
      bit_cnt    <= boundary ? 4'd0 : bit_cnt + 4'd1;
      case (state)
        HUNT: begin
          if (is_comma) begin
            bit_cnt      <= 4'd0;
            parallel_out <= win;
            word_valid   <= 1'b1;
            comma_det    <= 1'b1;
            good_cnt     <= 4'd1;
            if (LOCK_TH == 4'd1) begin
              state   <= LOCKED;
              bad_cnt <= 4'd0;
              locked  <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (boundary) begin
            parallel_out <= win;
            word_valid   <= 1'b1;
            comma_det    <= is_comma;
            if (is_comma) begin
              good_cnt <= good_inc;
              if (good_inc >= LOCK_TH) begin
                state   <= LOCKED;
                bad_cnt <= 4'd0;
                locked  <= 1'b1;
              end
            end
          end else if (is_comma) begin
            // A comma at a new phase restarts qualification from that phase.
            bit_cnt      <= 4'd0;
            parallel_out <= win;
            word_valid   <= 1'b1;
            comma_det    <= 1'b1;
            good_cnt     <= 4'd1;
          end
        end
        LOCKED: begin
          if (boundary) begin
            parallel_out <= win;
            word_valid   <= 1'b1;
            comma_det    <= is_comma;
            if (is_comma) begin
              bad_cnt <= 4'd0;
            end
          end else if (is_comma) begin
            if (bad_inc >= LOSS_TH) begin
              state        <= CHECK;
              bit_cnt      <= 4'd0;
              parallel_out <= win;
              word_valid   <= 1'b1;
              comma_det    <= 1'b1;
              good_cnt     <= 4'd1;
              bad_cnt      <= 4'd0;
              locked       <= 1'b0;
            end else begin
              bad_cnt <= bad_inc;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
